ps2_rx_fifo: RTL and testbench
==============================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FILTER_LEN, default 8: clkk cycles that synchronized ps2_clk must hold a level before the filtered clock changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 24000: idle clkk cycles allowed between falling edges inside a frame (1 ms at 24 MHz).
REQ-003 Parameter FIFO_DEPTH, default 8: byte capacity of the receive FIFO; power of two only.
REQ-004 clkk  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 ps2_clk  in  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-007 ps2_dat  in  1  raw PS/2 data from the keyboard, asynchronous.
REQ-008 rden  in  1  one-cycle pop request from the consumer.
REQ-009 q  out  8  scan code byte from the last pop.
REQ-010 dsr  out  1  data-set-ready; high while the FIFO is non-empty.
REQ-011 frame_err  out  1  one-cycle pulse when a frame is rejected (stop/parity/timeout).
REQ-012 overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 Filtered clock SHALL change only after the synchronized ps2_clk has held the new level for FILTER_LEN consecutive cycles; a falling edge of the filtered clock is the bit strobe.
REQ-015 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on strobe with ps2_dat=0 go to DATA with bit count 0; with ps2_dat=1 stay IDLE, no error.
REQ-017 DATA: each strobe shifts ps2_dat in LSB-first; after the 8th bit go to PARITY.
REQ-018 PARITY: the strobe captures the parity bit and goes to STOP.
REQ-019 STOP: on strobe go to IDLE; the byte is written when stop=1 and the 9 data+parity bits hold an odd number of ones; otherwise frame_err pulses and the byte is discarded.
REQ-020 In DATA, PARITY or STOP, TIMEOUT_CYCLES cycles without a strobe SHALL force IDLE, pulse frame_err, and discard the partial byte; the counter clears on every strobe and in IDLE.
REQ-021 FIFO write SHALL occur on the cycle after the STOP strobe; when full, the byte is dropped, overflow pulses, and contents are unchanged.
REQ-022 Pop: rden=1 with dsr=1 at edge N loads q with the head byte and advances the read pointer at edge N; q is valid from edge N onward and holds until the next pop.
REQ-023 rden=1 while empty SHALL be ignored; q and the pointers are unchanged.
REQ-024 A simultaneous write and pop SHALL both complete in the same cycle; a write into a full FIFO with a simultaneous pop is accepted without overflow.
REQ-025 dsr SHALL be registered and reflect occupancy after the current edge's write/pop; dsr falls on the edge that pops the last byte.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.

Reset
REQ-027 Reset SHALL set FSM=IDLE, bit count=0, shift register=0, timeout counter=0, pointers=0, q=8'h00, dsr=0, frame_err=0, overflow=0, and the filter to the idle-high level.
REQ-028 Reset asserted mid-frame SHALL abort the frame without a write or frame_err; the next start bit after reset is received normally.
REQ-029 FIFO storage contents need not be cleared.

Configuration
REQ-030 Macro PS2_RX_PARITY_CHECK_EN defined: parity is checked per REQ-019.
REQ-031 PS2_RX_PARITY_CHECK_EN undefined: the parity bit is sampled but ignored; only the stop bit and timeout can reject a frame.

Verification
REQ-032 Frame 0x1C with parity 0 and stop 1, then pulse rden once dsr=1 -> q=8'h1C on the rden edge, dsr=0 on the same edge, no error pulses.
REQ-033 Bytes F0 then 1C back-to-back, then two pops -> q=8'hF0 then 8'h1C, dsr falls after the second pop.
REQ-034 Frame 0x1C with parity 1 -> with the macro defined, frame_err pulses and dsr stays 0; without it, the byte is written with q=8'h1C.
REQ-035 9 good frames with no pops -> 8 stored, overflow pulses once, the pops return the first 8 bytes in order.
REQ-036 Start bit plus 3 data bits, then idle for TIMEOUT_CYCLES+1 cycles -> frame_err pulses, FSM=IDLE, and the next full frame 0x12 is received correctly.
REQ-037 A 3-cycle low glitch on ps2_clk while idle -> no strobe, no state change.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver (sync, glitch filter, frame FSM, timeout) feeding a byte FIFO; PS2_RX_PARITY_CHECK_EN enables parity checking; ports clkk/reset, ps2_clk/ps2_dat in, rden pop, q byte, dsr non-empty, frame_err/overflow pulses
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clkk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rden,
  output logic [7:0] q,
  output logic       dsr,
  output logic       frame_err,
  output logic       overflow
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, nstate;
  logic clk_s1, clk_s2, dat_s1, dat_s2, filt, strobe, par, par_ok, ok, bad, tmo_hit, wr_pend;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tmo;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic [AW:0] wp, rp, wp_n, rp_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic full, pop, push;
  always_ff @(posedge clkk)
    if (reset) {clk_s1, clk_s2, dat_s1, dat_s2} <= 4'hF;
    else {clk_s1, clk_s2, dat_s1, dat_s2} <= {ps2_clk, clk_s1, ps2_dat, dat_s1};
  always_ff @(posedge clkk)
    if (reset) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_s2 == filt) fcnt <= '0;
    else if (fcnt == FW'(FILTER_LEN - 1)) begin
      filt <= clk_s2;
      fcnt <= '0;
    end else fcnt <= fcnt + 1'b1;
  assign strobe = filt & ~clk_s2 & (fcnt == FW'(FILTER_LEN - 1));
`ifdef PS2_RX_PARITY_CHECK_EN
  assign par_ok = ^{shreg, par};
`else
  assign par_ok = 1'b1;
`endif
  always_ff @(posedge clkk)
    if (reset) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate  = state;
    ok      = 1'b0;
    bad     = 1'b0;
    tmo_hit = (state != IDLE) && !strobe && (tmo == TW'(TIMEOUT_CYCLES - 1));
    if (tmo_hit) begin
      nstate = IDLE;
      bad    = 1'b1;
    end else if (strobe)
      case (state)
        IDLE:   nstate = dat_s2 ? IDLE : DATA;
        DATA:   nstate = (bcnt == 3'd7) ? PARITY : DATA;
        PARITY: nstate = STOP;
        STOP: begin
          nstate = IDLE;
          ok     = dat_s2 & par_ok;
          bad    = ~(dat_s2 & par_ok);
        end
        default: nstate = IDLE;
      endcase
  end
  always_ff @(posedge clkk)
    if (reset) begin
      bcnt      <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tmo       <= '0;
      wr_pend   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad;
      wr_pend   <= ok;
      tmo       <= (state == IDLE || strobe || tmo_hit) ? '0 : tmo + 1'b1;
      if (strobe && state == IDLE) bcnt <= '0;
      if (strobe && state == DATA) begin
        shreg <= {dat_s2, shreg[7:1]};
        bcnt  <= bcnt + 1'b1;
      end
      if (strobe && state == PARITY) par <= dat_s2;
    end
  // shreg stays stable through the write cycle that follows the stop strobe
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop  = rden & dsr;
  assign push = wr_pend & (~full | pop);
  assign wp_n = wp + (AW+1)'(push);
  assign rp_n = rp + (AW+1)'(pop);
  always_ff @(posedge clkk)
    if (push) mem[wp[AW-1:0]] <= shreg;
  always_ff @(posedge clkk)
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      q        <= 8'h00;
      dsr      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wp       <= wp_n;
      rp       <= rp_n;
      dsr      <= wp_n != rp_n;
      overflow <= wr_pend & full & ~pop;
      if (pop) q <= mem[rp[AW-1:0]];
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed bench for ps2_rx_fifo
module tb_ps2_rx_fifo;
  localparam int TO = 200;
  logic clkk = 1'b0;
  logic reset, ps2_clk, ps2_dat, rden;
  logic [7:0] q;
  logic dsr, frame_err, overflow;
  int checks = 0, fails = 0, err_cnt = 0, ovf_cnt = 0;
  ps2_rx_fifo #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(8)) dut (
    .clkk(clkk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .rden(rden),
    .q(q), .dsr(dsr), .frame_err(frame_err), .overflow(overflow)
  );
  always #5 clkk = ~clkk;
  always @(negedge clkk) begin
    if (frame_err) err_cnt++;
    if (overflow) ovf_cnt++;
  end
  task automatic cyc(int n);
    repeat (n) @(negedge clkk);
  endtask
  task automatic send_bit(logic b);
    ps2_dat = b;
    cyc(10);
    ps2_clk = 1'b0;
    cyc(20);
    ps2_clk = 1'b1;
    cyc(10);
  endtask
  task automatic send_frame(logic [7:0] d, logic pflip, logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(~^d ^ pflip);
    send_bit(stop);
    ps2_dat = 1'b1;
    cyc(5);
  endtask
  task automatic pop();
    @(negedge clkk);
    rden = 1'b1;
    @(posedge clkk);
    #1;
    rden = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rden = 1'b0;
    cyc(5);
    checks++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q got %h want 00", q); end
    checks++; if (dsr !== 1'b0) begin fails++; $display("FAIL reset_dsr got %b want 0", dsr); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
    reset = 1'b0;
    cyc(5);
  endtask
  task automatic test_single();
    int e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (dsr !== 1'b1) begin fails++; $display("FAIL single_dsr_up got %b want 1", dsr); end
    pop();
    checks++; if (q !== 8'h1C) begin fails++; $display("FAIL single_q got %h want 1c", q); end
    checks++; if (dsr !== 1'b0) begin fails++; $display("FAIL single_dsr_down got %b want 0", dsr); end
    checks++; if (err_cnt != e0) begin fails++; $display("FAIL single_err got %0d want %0d", err_cnt, e0); end
  endtask
  task automatic test_back_to_back();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop();
    checks++; if (q !== 8'hF0) begin fails++; $display("FAIL b2b_q0 got %h want f0", q); end
    checks++; if (dsr !== 1'b1) begin fails++; $display("FAIL b2b_dsr0 got %b want 1", dsr); end
    pop();
    checks++; if (q !== 8'h1C) begin fails++; $display("FAIL b2b_q1 got %h want 1c", q); end
    checks++; if (dsr !== 1'b0) begin fails++; $display("FAIL b2b_dsr1 got %b want 0", dsr); end
  endtask
  task automatic test_parity();
    int e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_RX_PARITY_CHECK_EN
    checks++; if (err_cnt != e0 + 1) begin fails++; $display("FAIL parity_err got %0d want %0d", err_cnt, e0 + 1); end
    checks++; if (dsr !== 1'b0) begin fails++; $display("FAIL parity_dsr got %b want 0", dsr); end
`else
    checks++; if (err_cnt != e0) begin fails++; $display("FAIL parity_err got %0d want %0d", err_cnt, e0); end
    checks++; if (dsr !== 1'b1) begin fails++; $display("FAIL parity_dsr got %b want 1", dsr); end
    pop();
    checks++; if (q !== 8'h1C) begin fails++; $display("FAIL parity_q got %h want 1c", q); end
`endif
  endtask
  task automatic test_stop_bad();
    int e0 = err_cnt;
    send_frame(8'hA5, 1'b0, 1'b0);
    checks++; if (err_cnt != e0 + 1) begin fails++; $display("FAIL stop_err got %0d want %0d", err_cnt, e0 + 1); end
    checks++; if (dsr !== 1'b0) begin fails++; $display("FAIL stop_dsr got %b want 0", dsr); end
  endtask
  task automatic test_overflow();
    int o0 = ovf_cnt;
    logic [7:0] v;
    for (int i = 1; i <= 9; i++) begin
      v = 8'(i * 17);
      send_frame(v, 1'b0, 1'b1);
    end
    checks++; if (ovf_cnt != o0 + 1) begin fails++; $display("FAIL ovf_count got %0d want %0d", ovf_cnt, o0 + 1); end
    for (int i = 1; i <= 8; i++) begin
      v = 8'(i * 17);
      pop();
      checks++; if (q !== v) begin fails++; $display("FAIL ovf_pop%0d got %h want %h", i, q, v); end
    end
    checks++; if (dsr !== 1'b0) begin fails++; $display("FAIL ovf_empty got %b want 0", dsr); end
    pop();
    checks++; if (q !== 8'h88) begin fails++; $display("FAIL empty_pop_q got %h want 88", q); end
    checks++; if (dsr !== 1'b0) begin fails++; $display("FAIL empty_pop_dsr got %b want 0", dsr); end
  endtask
  task automatic test_timeout();
    int e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_dat = 1'b1;
    cyc(TO + 20);
    checks++; if (err_cnt != e0 + 1) begin fails++; $display("FAIL timeout_err got %0d want %0d", err_cnt, e0 + 1); end
    send_frame(8'h12, 1'b0, 1'b1);
    checks++; if (dsr !== 1'b1) begin fails++; $display("FAIL timeout_dsr got %b want 1", dsr); end
    pop();
    checks++; if (q !== 8'h12) begin fails++; $display("FAIL timeout_q got %h want 12", q); end
  endtask
  task automatic test_glitch();
    int e0 = err_cnt;
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    cyc(20);
    ps2_dat = 1'b1;
    cyc(5);
    checks++; if (err_cnt != e0) begin fails++; $display("FAIL glitch_err got %0d want %0d", err_cnt, e0); end
    checks++; if (dsr !== 1'b0) begin fails++; $display("FAIL glitch_dsr got %b want 0", dsr); end
    send_frame(8'h5A, 1'b0, 1'b1);
    pop();
    checks++; if (q !== 8'h5A) begin fails++; $display("FAIL glitch_q got %h want 5a", q); end
  endtask
  task automatic test_reset_midframe();
    int e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(5);
    checks++; if (q !== 8'h00) begin fails++; $display("FAIL rstmid_q got %h want 00", q); end
    checks++; if (dsr !== 1'b0) begin fails++; $display("FAIL rstmid_dsr got %b want 0", dsr); end
    send_frame(8'h33, 1'b0, 1'b1);
    checks++; if (err_cnt != e0) begin fails++; $display("FAIL rstmid_err got %0d want %0d", err_cnt, e0); end
    pop();
    checks++; if (q !== 8'h33) begin fails++; $display("FAIL rstmid_q2 got %h want 33", q); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_stop_bad();
    test_overflow();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
